aibnd_data_buf_fifo: RTL and testbench

//  Parametrised successor to the single-bit aibnd data buffer: a WIDTH-bit, DEPTH-entry

---
 rtl/aibnd_data_buf_pkg.sv | 11 +
 rtl/aibnd_data_buf_fifo_if.sv | 27 ++
 rtl/aibnd_data_buf_mem.sv | 21 ++
 rtl/aibnd_data_buf_fifo.sv | 74 +++++++
 tb/tb_aibnd_data_buf_fifo.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/aibnd_data_buf_pkg.sv
// aibnd_data_buf_pkg: shared widths, mode encodings and parameter checks for the aibnd data buffer
package aibnd_data_buf_pkg;
    localparam logic AIBND_MODE_BUF = 1'b0;
    localparam logic AIBND_MODE_BYP = 1'b1;
    function automatic int cntw(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic bit params_ok(input int width, input int depth);
        return width >= 1 && depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/aibnd_data_buf_fifo_if.sv
// aibnd_data_buf_fifo_if: upstream/downstream handshakes plus mode and status of the data buffer
interface aibnd_data_buf_fifo_if
    import aibnd_data_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) ();
    localparam int CNTW = cntw(DEPTH);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             bypass_req;
    logic             flush;
    logic             bypass_act;
    logic [CNTW-1:0]  fill_cnt;
    modport master (
        output in_valid, in_data, out_ready, bypass_req, flush,
        input  in_ready, out_valid, out_data, bypass_act, fill_cnt
    );
    modport slave (
        input  in_valid, in_data, out_ready, bypass_req, flush,
        output in_ready, out_valid, out_data, bypass_act, fill_cnt
    );
endinterface

// File: rtl/aibnd_data_buf_mem.sv
// aibnd_data_buf_mem: DEPTH x WIDTH flop array, one write port, one asynchronous read port
module aibnd_data_buf_mem
    import aibnd_data_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/aibnd_data_buf_fifo.sv
// aibnd_data_buf_fifo: WIDTH x DEPTH elastic buffer with drain-safe zero-latency bypass mode
module aibnd_data_buf_fifo
    import aibnd_data_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vccl_aibnd,
    input  logic                  vssl_aibnd,
    aibnd_data_buf_fifo_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = cntw(DEPTH);

    if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
        $error("aibnd_data_buf_fifo: WIDTH must be >=1 and DEPTH a power of two >=2");
    end

    typedef enum logic [1:0] {ST_BUF, ST_DRAIN, ST_BYP} state_t;

    state_t           state, state_nxt;
    logic [CNTW-1:0]  wr_ptr, rd_ptr, cnt;
    logic [WIDTH-1:0] rd_data;
    logic             rdy_q, full, empty, byp, buf_ready, push, pop;
    logic             unused_pins;

    assign unused_pins = vccl_aibnd ^ vssl_aibnd;

    // Pointers carry one extra wrap bit, so their difference is the fill count
    assign cnt       = wr_ptr - rd_ptr;
    assign empty     = cnt == '0;
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
    assign byp       = state == ST_BYP;
    assign buf_ready = rdy_q & !full & !(bus.bypass_req & !byp);
    assign push      = !byp & bus.in_valid & buf_ready & !bus.flush;
    assign pop       = !byp & !empty & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_BUF;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdy_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_q  <= 1'b1;
            wr_ptr <= bus.flush ? '0 : wr_ptr + CNTW'(push);
            rd_ptr <= bus.flush ? '0 : rd_ptr + CNTW'(pop);
        end
    end

    // Requests from BUF wait in DRAIN until every stored word has left
    always_comb begin
        state_nxt = state;
        state_nxt = !bus.bypass_req ? ST_BUF : (byp || empty) ? ST_BYP : ST_DRAIN;
    end

    aibnd_data_buf_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.in_ready   = byp ? bus.out_ready : buf_ready;
    assign bus.out_valid  = byp ? bus.in_valid : !empty;
    assign bus.out_data   = byp ? bus.in_data : empty ? '0 : rd_data;
    assign bus.bypass_act = byp ? AIBND_MODE_BYP : AIBND_MODE_BUF;
    assign bus.fill_cnt   = cnt;
endmodule

// File: tb/tb_aibnd_data_buf_fifo.sv
// tb_aibnd_data_buf_fifo: table-driven directed checks plus hand sequences for reset, wrap and reset mid-stream
module tb_aibnd_data_buf_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    aibnd_data_buf_fifo_if #(.WIDTH(32), .DEPTH(4)) bus ();

    aibnd_data_buf_fifo #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vccl_aibnd (1'b1),
        .vssl_aibnd (1'b0),
        .bus        (bus)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        breq;
        logic        fl;
        logic        eov;
        logic [31:0] eod;
        logic        eir;
        logic [2:0]  ecnt;
        logic        eba;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] d, input logic ordy, input logic breq,
                       input logic fl, input logic eov, input logic [31:0] eod, input logic eir,
                       input logic [2:0] ecnt, input logic eba);
        vec_t v;
        v = '{iv, d, ordy, breq, fl, eov, eod, eir, ecnt, eba};
        vq.push_back(v);
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic breq, input logic fl);
        bus.in_valid   = iv;
        bus.in_data    = d;
        bus.out_ready  = ordy;
        bus.bypass_req = breq;
        bus.flush      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        // legacy-style table: each row is one cycle, expectations sampled before the edge
        add(1, 32'h11, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'h22, 0, 0, 0,  1, 32'h11, 1, 1, 0);
        add(1, 32'h33, 0, 0, 0,  1, 32'h11, 1, 2, 0);
        add(1, 32'h44, 0, 0, 0,  1, 32'h11, 1, 3, 0);
        add(1, 32'h55, 0, 0, 0,  1, 32'h11, 0, 4, 0);
        add(1, 32'h55, 1, 0, 0,  1, 32'h11, 0, 4, 0);
        add(0, 32'h00, 0, 0, 0,  1, 32'h22, 1, 3, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h22, 1, 3, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h33, 1, 2, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h44, 1, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'hAA, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'hBB, 0, 0, 0,  1, 32'hAA, 1, 1, 0);
        add(0, 32'h00, 0, 1, 0,  1, 32'hAA, 0, 2, 0);
        add(1, 32'hCC, 1, 1, 0,  1, 32'hAA, 0, 2, 0);
        add(0, 32'h00, 1, 1, 0,  1, 32'hBB, 0, 1, 0);
        add(0, 32'h00, 1, 1, 0,  0, 32'h00, 0, 0, 0);
        add(1, 32'hA5, 1, 1, 0,  1, 32'hA5, 1, 0, 1);
        add(1, 32'h5A, 0, 1, 1,  1, 32'h5A, 0, 0, 1);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 0, 0, 1);
        add(1, 32'h66, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h66, 1, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'h77, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(0, 32'h00, 0, 1, 0,  1, 32'h77, 0, 1, 0);
        add(0, 32'h00, 0, 1, 0,  1, 32'h77, 0, 1, 0);
        add(1, 32'h88, 0, 0, 0,  1, 32'h77, 1, 1, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h77, 1, 2, 0);
        add(0, 32'h00, 1, 0, 0,  1, 32'h88, 1, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'h91, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(1, 32'h92, 0, 0, 0,  1, 32'h91, 1, 1, 0);
        add(1, 32'h93, 0, 0, 0,  1, 32'h91, 1, 2, 0);
        add(1, 32'h94, 0, 0, 1,  1, 32'h91, 1, 3, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0, 0);
        add(0, 32'h00, 1, 0, 0,  0, 32'h00, 1, 0, 0);

        #1;
        chk("rst in_ready", 32'(bus.in_ready), 0);
        chk("rst out_valid", 32'(bus.out_valid), 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst fill_cnt", 32'(bus.fill_cnt), 0);
        chk("rst bypass_act", 32'(bus.bypass_act), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready before clk", 32'(bus.in_ready), 0);
        tick();
        chk("release in_ready after clk", 32'(bus.in_ready), 1);

        foreach (vq[i]) begin
            drive(vq[i].iv, vq[i].d, vq[i].ordy, vq[i].breq, vq[i].fl);
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(vq[i].eov));
            chk($sformatf("row%0d out_data", i), bus.out_data, vq[i].eod);
            chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vq[i].eir));
            chk($sformatf("row%0d fill_cnt", i), 32'(bus.fill_cnt), 32'(vq[i].ecnt));
            chk($sformatf("row%0d bypass_act", i), 32'(bus.bypass_act), 32'(vq[i].eba));
            tick();
        end

        // steady push+pop at fill 2 across several pointer wraps
        drive(1, 1, 0, 0, 0);
        tick();
        drive(1, 2, 0, 0, 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(1, 32'(k + 3), 1, 0, 0);
            #1;
            chk($sformatf("pp%0d out_data", k), bus.out_data, 32'(k + 1));
            chk($sformatf("pp%0d fill_cnt", k), 32'(bus.fill_cnt), 2);
            tick();
        end
        drive(0, 0, 1, 0, 0);
        #1;
        chk("pp tail0", bus.out_data, 11);
        tick();
        chk("pp tail1", bus.out_data, 12);
        tick();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("pp empty", 32'(bus.out_valid), 0);

        // asynchronous reset with three words stored
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'hE1 + 32'(k), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("pre-rst fill_cnt", 32'(bus.fill_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst fill_cnt", 32'(bus.fill_cnt), 0);
        chk("mid-rst out_valid", 32'(bus.out_valid), 0);
        chk("mid-rst out_data", bus.out_data, 0);
        chk("mid-rst in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst in_ready", 32'(bus.in_ready), 1);
        chk("post-rst out_valid", 32'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
